// File: rtl/sfu_log_pkg.sv
// Shared constants and helpers for the SFU log2 correction LUT arbiter.
package sfu_log_pkg;

   localparam int DEF_ADDR_WIDTH = 5;   // 32-entry correction LUT
   localparam int DEF_DATA_WIDTH = 20;
   localparam int LUT_LATENCY    = 1;   // registered LUT read ports

   // Width of a requester index; a single requester still needs one bit.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Next requester index with wrap-around.
   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Masked find-first: returns the first set request at or after i_ptr, with wrap.
module rr_pick
   import sfu_log_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = id_width(N)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic          o_valid,
   output logic [IW-1:0] o_idx
);

   // Scan from the farthest candidate back towards the pointer so the closest hit wins.
   always_comb begin
      // NOTE: every output gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
      o_valid = 1'b0;
      o_idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (i_req[IW'((int'(i_ptr) + k) % N)]) begin
            o_valid = 1'b1;
            o_idx   = IW'((int'(i_ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/log_lut_arbiter.sv
// Round-robin arbiter sharing the two read ports of the log2 correction LUT
// among NUM_REQ requesters, with per-requester response slots.
module log_lut_arbiter
   import sfu_log_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data,
   input  logic [NUM_REQ-1:0]            rsp_ready,
   output logic                          lut_en,
   output logic [ADDR_WIDTH-1:0]         lut_addr_a,
   output logic [ADDR_WIDTH-1:0]         lut_addr_b,
   input  logic [DATA_WIDTH-1:0]         lut_q_a,
   input  logic [DATA_WIDTH-1:0]         lut_q_b
);

   localparam int IW = id_width(NUM_REQ);

   logic                          r_s1_valid_a;
   logic                          r_s1_valid_b;
   logic [IW-1:0]                 r_s1_id_a;
   logic [IW-1:0]                 r_s1_id_b;
   logic [IW-1:0]                 r_rr_ptr;
   logic [NUM_REQ-1:0]            r_rsp_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0] r_rsp_data;

   logic [NUM_REQ-1:0]            w_pending;
   logic [NUM_REQ-1:0]            w_eligible;
   logic [NUM_REQ-1:0]            w_eligible_b;
   logic [NUM_REQ-1:0]            w_onehot_a;
   logic [NUM_REQ-1:0]            w_onehot_b;
   logic                          w_grant_a;
   logic                          w_grant_b;
   logic [IW-1:0]                 w_idx_a;
   logic [IW-1:0]                 w_idx_b;
   logic [IW-1:0]                 w_ptr_b;

   // Eligibility: not in flight and with a free (or draining) response slot; nothing while in reset.
   always_comb begin
      w_pending = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_pending[i] = (r_s1_valid_a && (r_s1_id_a == IW'(i))) ||
                        (r_s1_valid_b && (r_s1_id_b == IW'(i)));
      end
      w_eligible = rst_n ? (req_valid & ~w_pending & (~r_rsp_valid | rsp_ready)) : '0;
   end

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_a (
      .i_req   (w_eligible),
      .i_ptr   (r_rr_ptr),
      .o_valid (w_grant_a),
      .o_idx   (w_idx_a)
   );

   // Port B searches from just past A's grant with A removed; a lone requester never uses B.
   always_comb begin
      w_onehot_a = '0;
      if (w_grant_a) w_onehot_a[w_idx_a] = 1'b1;
      w_ptr_b      = IW'(wrap_inc(int'(w_idx_a), NUM_REQ));
      w_eligible_b = (NUM_REQ > 1) ? (w_eligible & ~w_onehot_a) : '0;
   end

   rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_b (
      .i_req   (w_eligible_b),
      .i_ptr   (w_ptr_b),
      .o_valid (w_grant_b),
      .o_idx   (w_idx_b)
   );

   // Grant decode and LUT port drive; an idle port presents address zero.
   always_comb begin
      w_onehot_b = '0;
      if (w_grant_b) w_onehot_b[w_idx_b] = 1'b1;
      req_ready  = w_onehot_a | w_onehot_b;
      lut_en     = w_grant_a | w_grant_b;
      lut_addr_a = w_grant_a ? req_addr[int'(w_idx_a)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
      lut_addr_b = w_grant_b ? req_addr[int'(w_idx_b)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   end

   // Stage-1 tracking of the LUT read, response capture/drain, and round-robin pointer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_s1_valid_a <= 1'b0;
         r_s1_valid_b <= 1'b0;
         r_s1_id_a    <= '0;
         r_s1_id_b    <= '0;
         r_rr_ptr     <= '0;
         r_rsp_valid  <= '0;
         // NOTE: response data slots are reset as well, so a slot reads zero rather than stale data after reset.
         r_rsp_data   <= '0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
         r_s1_valid_a <= w_grant_a;
         r_s1_valid_b <= w_grant_b;
         r_s1_id_a    <= w_idx_a;
         r_s1_id_b    <= w_idx_b;
         if (w_grant_b) begin
            r_rr_ptr <= IW'(wrap_inc(int'(w_idx_b), NUM_REQ));
         end else if (w_grant_a) begin
            r_rr_ptr <= IW'(wrap_inc(int'(w_idx_a), NUM_REQ));
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (r_s1_valid_a && (r_s1_id_a == IW'(i))) begin
               r_rsp_data[i*DATA_WIDTH +: DATA_WIDTH] <= lut_q_a;
               r_rsp_valid[i]                         <= 1'b1;
            end else if (r_s1_valid_b && (r_s1_id_b == IW'(i))) begin
               r_rsp_data[i*DATA_WIDTH +: DATA_WIDTH] <= lut_q_b;
               r_rsp_valid[i]                         <= 1'b1;
            end else if (r_rsp_valid[i] && rsp_ready[i]) begin
               r_rsp_valid[i] <= 1'b0;
            end
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_log_lut_arbiter.sv
// Directed bench for log_lut_arbiter with a behavioural dual-port LUT and a response scoreboard.
module tb_log_lut_arbiter;
   import sfu_log_pkg::*;

   localparam int N  = 4;
   localparam int AW = 5;
   localparam int DW = 20;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic [N*DW-1:0] rsp_data;
   logic [N-1:0]    rsp_ready;
   logic            lut_en;
   logic [AW-1:0]   lut_addr_a;
   logic [AW-1:0]   lut_addr_b;
   logic [DW-1:0]   lut_q_a = '0;
   logic [DW-1:0]   lut_q_b = '0;

   typedef struct {
      int          id;
      logic [DW-1:0] data;
      int          due;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc_n = 0;

   always #5 clk = ~clk;

   log_lut_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data),
      .rsp_ready  (rsp_ready),
      .lut_en     (lut_en),
      .lut_addr_a (lut_addr_a),
      .lut_addr_b (lut_addr_b),
      .lut_q_a    (lut_q_a),
      .lut_q_b    (lut_q_b)
   );

   // LUT contents: the entries exercised by name plus a recognisable filler.
   function automatic logic [DW-1:0] lut_fn(input logic [AW-1:0] a);
      case (a)
         5'd0:    lut_fn = 20'h00362;
         5'd1:    lut_fn = 20'h00668;
         5'd2:    lut_fn = 20'h0091D;
         5'd3:    lut_fn = 20'h00B84;
         5'd8:    lut_fn = 20'h0138C;
         5'd13:   lut_fn = 20'h0160B;
         5'd31:   lut_fn = 20'h00000;
         default: lut_fn = 20'h80000 | {15'd0, a};
      endcase
   endfunction

   // Registered dual-port LUT model, one cycle of read latency.
   always @(posedge clk) begin
      if (lut_en) begin
         lut_q_a <= lut_fn(lut_addr_a);
         lut_q_b <= lut_fn(lut_addr_b);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc_n);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   // Compare every scoreboard entry that is due in the current cycle.
   task automatic sb_check();
      for (int k = sb_q.size() - 1; k >= 0; k--) begin
         if (sb_q[k].due == cyc_n) begin
            check($sformatf("sb_valid[%0d]", sb_q[k].id), 32'(rsp_valid[sb_q[k].id]), 32'd1);
            check($sformatf("sb_data[%0d]", sb_q[k].id),
                  32'(rsp_data[sb_q[k].id*DW +: DW]), 32'(sb_q[k].data));
            sb_q.delete(k);
         end
      end
   endtask

   task automatic settle();
      #2;
      sb_check();
   endtask

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      req_addr[i*AW +: AW] = a;
   endtask

   // A grant in this cycle yields a response two cycles later.
   task automatic push(input int id, input logic [AW-1:0] a);
      exp_t e;
      e.id   = id;
      e.data = lut_fn(a);
      e.due  = cyc_n + LUT_LATENCY + 1;
      sb_q.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = 4'b1111;
      req_addr  = '0;
      rsp_ready = 4'b1111;
      for (int i = 0; i < N; i++) set_addr(i, AW'(i));

      // Reset held for three cycles with all requests up.
      for (int c = 0; c < 3; c++) begin
         cyc(); settle();
         check("rst_req_ready", 32'(req_ready), 32'h0);
         check("rst_lut_en", 32'(lut_en), 32'h0);
         check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
         check("rst_lut_addr_a", 32'(lut_addr_a), 32'h0);
      end

      // Release; four continuous requesters alternate {0,1} and {2,3}.
      for (int c = 0; c < 6; c++) begin
         cyc();
         rst_n = 1'b1;
         settle();
         check("cont_req_ready", 32'(req_ready), (c % 2 == 0) ? 32'h3 : 32'hC);
         check("cont_lut_addr_a", 32'(lut_addr_a), (c % 2 == 0) ? 32'd0 : 32'd2);
         check("cont_lut_addr_b", 32'(lut_addr_b), (c % 2 == 0) ? 32'd1 : 32'd3);
         check("cont_rsp_valid", 32'(rsp_valid),
               (c < 2) ? 32'h0 : ((c % 2 == 0) ? 32'h3 : 32'hC));
         if (c % 2 == 0) begin push(0, 5'd0); push(1, 5'd1); end
         else            begin push(2, 5'd2); push(3, 5'd3); end
      end
      for (int c = 0; c < 3; c++) begin
         cyc(); req_valid = '0; settle();
         check("drain_req_ready", 32'(req_ready), 32'h0);
      end
      check("drain_rsp_valid", 32'(rsp_valid), 32'h0);

      // Single request: requester 2, address 13.
      cyc(); set_addr(2, 5'd13); req_valid = 4'b0100; settle();
      check("single_req_ready", 32'(req_ready), 32'h4);
      check("single_lut_en", 32'(lut_en), 32'h1);
      check("single_lut_addr_a", 32'(lut_addr_a), 32'd13);
      check("single_lut_addr_b", 32'(lut_addr_b), 32'd0);
      push(2, 5'd13);
      cyc(); req_valid = '0; settle();
      check("single_rsp_early", 32'(rsp_valid), 32'h0);
      cyc(); settle();
      check("single_rsp_valid", 32'(rsp_valid), 32'h4);
      check("single_rsp_data", 32'(rsp_data[2*DW +: DW]), 32'h160B);

      // Backpressure on requester 1 holding 0x138C.
      cyc(); rsp_ready = 4'b1101; set_addr(1, 5'd8); req_valid = 4'b0010; settle();
      check("bp_first_grant", 32'(req_ready), 32'h2);
      push(1, 5'd8);
      cyc(); set_addr(1, 5'd5); settle();
      check("bp_pending_block", 32'(req_ready), 32'h0);
      cyc(); settle();
      check("bp_full_block", 32'(req_ready), 32'h0);
      for (int c = 0; c < 2; c++) begin
         cyc(); settle();
         check("bp_hold_ready", 32'(req_ready), 32'h0);
         check("bp_hold_valid", 32'(rsp_valid[1]), 32'h1);
         check("bp_hold_data", 32'(rsp_data[1*DW +: DW]), 32'h138C);
      end
      cyc(); rsp_ready = 4'b1111; settle();
      check("bp_release_grant", 32'(req_ready), 32'h2);
      check("bp_release_addr", 32'(lut_addr_a), 32'd5);
      push(1, 5'd5);
      cyc(); req_valid = '0; settle();
      check("bp_drained", 32'(rsp_valid), 32'h0);
      cyc(); settle();

      // Drain and regrant in the same cycle on requester 0.
      cyc(); rsp_ready = 4'b1110; set_addr(0, 5'd2); req_valid = 4'b0001; settle();
      check("dr_setup_grant", 32'(req_ready), 32'h1);
      push(0, 5'd2);
      cyc(); req_valid = '0; settle();
      cyc(); settle();
      cyc(); rsp_ready = 4'b1111; set_addr(0, 5'd31); req_valid = 4'b0001; settle();
      check("dr_held_valid", 32'(rsp_valid[0]), 32'h1);
      check("dr_regrant", 32'(req_ready), 32'h1);
      check("dr_lut_addr", 32'(lut_addr_a), 32'd31);
      push(0, 5'd31);
      cyc(); req_valid = '0; settle();
      check("dr_gap", 32'(rsp_valid[0]), 32'h0);
      cyc(); settle();

      // Reset while requesters 3 (A) and 0 (B) are in flight; pointer sits at 1 beforehand.
      cyc(); for (int i = 0; i < N; i++) set_addr(i, AW'(i)); req_valid = 4'b1001; settle();
      check("mf_grant", 32'(req_ready), 32'h9);
      check("mf_lut_addr_a", 32'(lut_addr_a), 32'd3);
      check("mf_lut_addr_b", 32'(lut_addr_b), 32'd0);
      cyc(); rst_n = 1'b0; req_valid = 4'b1111; settle();
      check("mf_rst_ready", 32'(req_ready), 32'h0);
      check("mf_rst_lut_en", 32'(lut_en), 32'h0);
      cyc(); rst_n = 1'b1; settle();
      check("mf_dropped", 32'(rsp_valid), 32'h0);
      check("mf_ptr_reset", 32'(req_ready), 32'h3);
      push(0, 5'd0); push(1, 5'd1);
      cyc(); req_valid = '0; settle();
      check("mf_no_late_rsp", 32'(rsp_valid), 32'h0);
      cyc(); settle();
      check("mf_post_rsp", 32'(rsp_valid), 32'h3);
      cyc(); settle();
      check("mf_idle", 32'(rsp_valid), 32'h0);

      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
